// File: rtl/operand_fetcher_if.sv
// operand_fetcher_if: memory read port plus the output word stream of the operand fetcher.
// master = fetcher side, slave = memory/consumer side.
interface operand_fetcher_if #(
    parameter int unsigned width    = 128,
    parameter int unsigned log_size = 10
);
    logic [log_size-1:0] out_mem_address;
    logic                out_mem_read_en;
    logic [width-1:0]    in_mem_data;
    logic [width-1:0]    out_data;
    logic                out_valid;
    logic                in_ready;

    modport master (
        output out_mem_address, out_mem_read_en, out_data, out_valid,
        input  in_mem_data, in_ready
    );

    modport slave (
        input  out_mem_address, out_mem_read_en, out_data, out_valid,
        output in_mem_data, in_ready
    );
endinterface

// File: rtl/operand_fetcher.sv
// operand_fetcher: walks a run of multi-cell words in block memory, absorbs the memory's
// one-cycle read latency and streams words out through a 2-entry skid FIFO.
// Optional feature: define OPFETCH_STRIDE_EN to add the in_stride port (programmable
// address increment); otherwise words are contiguous (increment = blocks).
module operand_fetcher #(
    parameter int unsigned size       = 1024,
    parameter int unsigned blocks     = 4,
    parameter int unsigned log_size   = 10,
    parameter int unsigned cell_width = 32,
    localparam int unsigned width     = blocks * cell_width
) (
    input  logic                in_clk,
    input  logic                in_reset,
    input  logic                in_start,
    input  logic [log_size-1:0] in_base_addr,
    input  logic [log_size:0]   in_count,
`ifdef OPFETCH_STRIDE_EN
    input  logic [log_size-1:0] in_stride,
`endif
    operand_fetcher_if.master   bus,
    output logic                out_busy,
    output logic                out_done
);

    localparam logic [log_size-1:0] AddrMask = log_size'(size - 1);
    localparam logic [log_size-1:0] Step     = log_size'(blocks);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e              state_q, state_d;
    logic [log_size-1:0] addr_q;
    logic [log_size:0]   count_q, issued_q;
    logic                setup_q;
    logic                inflight_q;
    logic                zero_done_q;
    logic [width-1:0]    fifo_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          occ_q;
`ifdef OPFETCH_STRIDE_EN
    logic [log_size-1:0] stride_q;
`endif

    logic                pop, push, room, issue, drain_done, accept;
    logic [2:0]          pending;
    logic [log_size-1:0] step, addr_next;

`ifdef OPFETCH_STRIDE_EN
    assign step = stride_q;
`else
    assign step = Step;
`endif

    assign pop        = bus.out_valid && bus.in_ready;
    assign push       = inflight_q;
    // Reads already committed to the FIFO: stored words plus the one on the memory bus.
    assign pending    = {1'b0, occ_q} + {2'b00, inflight_q};
    assign room       = pending < (3'd2 + {2'b00, pop});
    // setup_q holds off the first FETCH cycle so the first read lands one edge after start.
    assign issue      = (state_q == StFetch) && !setup_q && room;
    assign drain_done = (state_q == StDrain) && (occ_q == 2'd0) && !inflight_q;
    assign accept     = (state_q == StIdle) && in_start && (in_count != '0);
    assign addr_next  = (addr_q + step) & AddrMask;

    assign bus.out_mem_address = addr_q;
    assign bus.out_mem_read_en = issue;
    assign bus.out_data        = fifo_q[rd_ptr_q];
    assign bus.out_valid       = occ_q != 2'd0;
    assign out_busy            = state_q != StIdle;
    assign out_done            = drain_done || zero_done_q;

    // Next-state logic for the run sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StFetch;
            StFetch: if (issue && (issued_q + (log_size + 1)'(1) == count_q)) state_d = StDrain;
            StDrain: if (drain_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) state_q <= StIdle;
        else           state_q <= state_d;
    end

    // Run parameters, address walk, in-flight tracking and zero-count done pulse.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            addr_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            setup_q     <= 1'b0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
`ifdef OPFETCH_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            inflight_q  <= issue;
            zero_done_q <= (state_q == StIdle) && in_start && (in_count == '0);
            if (accept) begin
                addr_q   <= in_base_addr;
                count_q  <= in_count;
                issued_q <= '0;
                setup_q  <= 1'b1;
`ifdef OPFETCH_STRIDE_EN
                stride_q <= in_stride;
`endif
            end else if (state_q == StFetch) begin
                setup_q <= 1'b0;
                if (issue) begin
                    addr_q   <= addr_next;
                    issued_q <= issued_q + (log_size + 1)'(1);
                end
            end
        end
    end

    // Two-entry skid FIFO; push only on the cycle the memory drives valid data.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.in_mem_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_operand_fetcher.sv
// tb_operand_fetcher: table-driven runs against a registered-read memory model, with
// scoreboards for issued addresses and delivered words, plus hand-written reset sequences.
module tb_operand_fetcher;

    localparam int unsigned Width = 128;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base;
    logic [10:0] count;
`ifdef OPFETCH_STRIDE_EN
    logic [9:0]  stride;
`endif
    logic        busy, done;

    operand_fetcher_if #(.width(Width), .log_size(10)) bus ();

    operand_fetcher dut (
        .in_clk       (clk),
        .in_reset     (rst_n),
        .in_start     (start),
        .in_base_addr (base),
        .in_count     (count),
`ifdef OPFETCH_STRIDE_EN
        .in_stride    (stride),
`endif
        .bus          (bus),
        .out_busy     (busy),
        .out_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: cell i = i, one-cycle registered read, garbage when not driven.
    logic [31:0]      mem [1024];
    logic [Width-1:0] mem_q;
    logic             mem_vld;

    function automatic logic [Width-1:0] mem_word(input logic [9:0] a);
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_vld <= 1'b0;
        else begin
            mem_vld <= bus.out_mem_read_en;
            if (bus.out_mem_read_en) mem_q <= mem_word(bus.out_mem_address);
        end
    end
    assign bus.in_mem_data = mem_vld ? mem_q : {4{32'hDEADBEEF}};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [Width-1:0] act,
                         input logic [Width-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [Width-1:0] exp_word(input int a);
        logic [Width-1:0] w;
        for (int j = 0; j < 4; j++) w[j*32 +: 32] = 32'((a + j) % 1024);
        return w;
    endfunction

    // Scoreboards.
    logic [9:0]       exp_addr [$];
    logic [Width-1:0] exp_data [$];
    int               tb_occ;
    int               pops_total;
    int               done_cnt;
    bit               stall_prev;
    logic [Width-1:0] held;
    logic             m_push, m_pop;

    // Monitor on the falling edge: addresses, words, stall stability, issue flow control.
    always @(negedge clk) begin
        if (rst_n) begin
            m_push = mem_vld;
            m_pop  = bus.out_valid && bus.in_ready;
            if (bus.out_mem_read_en) begin
                check("issue_room", 128'((tb_occ + int'(m_push) - int'(m_pop)) < 2), 128'd1);
                if (exp_addr.size() == 0) check("unexpected_read", 128'd1, 128'd0);
                else check("read_addr", 128'(bus.out_mem_address), 128'(exp_addr.pop_front()));
            end
            if (m_pop) begin
                pops_total++;
                if (exp_data.size() == 0) check("unexpected_word", 128'd1, 128'd0);
                else check("word", bus.out_data, exp_data.pop_front());
            end
            if (stall_prev) check("stall_hold", bus.out_data, held);
            stall_prev = bus.out_valid && !bus.in_ready;
            held       = bus.out_data;
            if (done) done_cnt++;
            tb_occ = tb_occ + int'(m_push) - int'(m_pop);
        end else begin
            stall_prev = 1'b0;
            tb_occ     = 0;
        end
    end

    typedef struct {
        logic [9:0]  base;
        logic [10:0] count;
        logic [9:0]  stride;
        logic [3:0]  ready;   // ready pattern, bit (cycle % 4)
        bit          poke;    // pulse in_start again while busy
        int          exp_cyc; // cycles from start edge to done, -1 = not checked
    } vec_t;

    vec_t vecs[8];

    task automatic push_expect(input int b, input int n, input int step);
        for (int k = 0; k < n; k++) begin
            int a;
            a = (b + k * step) % 1024;
            exp_addr.push_back(10'(a));
            exp_data.push_back(exp_word(a));
        end
    endtask

    task automatic do_run(input vec_t v);
        int cyc;
        int first_valid;
        int step;
        bit got_done;
`ifdef OPFETCH_STRIDE_EN
        step   = int'(v.stride);
        stride = v.stride;
`else
        step = 4;
`endif
        done_cnt = 0;
        push_expect(int'(v.base), int'(v.count), step);
        base  = v.base;
        count = v.count;
        start = 1'b1;
        bus.in_ready = v.ready[0];
        @(posedge clk);
        #1;
        cyc = 0; first_valid = -1; got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            bus.in_ready = v.ready[cyc % 4];
            if (v.poke && cyc == 2) begin
                start = 1'b1; base = 10'd3; count = 11'd9;
            end else start = 1'b0;
            @(negedge clk);
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (done) got_done = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 128'(got_done), 128'd1);
        if (v.exp_cyc >= 0) check("done_latency", 128'(cyc), 128'(v.exp_cyc));
        check("first_valid", 128'(first_valid), 128'((v.count != 0) ? 3 : -1));
        bus.in_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("addr_q_empty", 128'(exp_addr.size()), 128'd0);
        check("data_q_empty", 128'(exp_data.size()), 128'd0);
        check("single_done", 128'(done_cnt), 128'd1);
        check("idle_busy", 128'(busy), 128'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  128'(bus.out_mem_address), 128'd0);
        check({tag, "_rden"},  128'(bus.out_mem_read_en), 128'd0);
        check({tag, "_data"},  bus.out_data, 128'd0);
        check({tag, "_valid"}, 128'(bus.out_valid), 128'd0);
        check({tag, "_busy"},  128'(busy), 128'd0);
        check({tag, "_done"},  128'(done), 128'd0);
    endtask

    initial begin
        vecs[0] = '{base: 10'd0,    count: 11'd10, stride: 10'd4, ready: 4'b1111, poke: 0, exp_cyc: 13};
        vecs[1] = '{base: 10'd0,    count: 11'd10, stride: 10'd4, ready: 4'b1001, poke: 0, exp_cyc: -1};
        vecs[2] = '{base: 10'd0,    count: 11'd0,  stride: 10'd4, ready: 4'b1111, poke: 0, exp_cyc: 0};
        vecs[3] = '{base: 10'd1016, count: 11'd3,  stride: 10'd4, ready: 4'b1111, poke: 0, exp_cyc: 6};
        vecs[4] = '{base: 10'd200,  count: 11'd3,  stride: 10'd4, ready: 4'b1111, poke: 1, exp_cyc: 6};
        vecs[5] = '{base: 10'd0,    count: 11'd4,  stride: 10'd8, ready: 4'b1111, poke: 0, exp_cyc: 7};
        vecs[6] = '{base: 10'd40,   count: 11'd3,  stride: 10'd0, ready: 4'b0110, poke: 0, exp_cyc: -1};
        vecs[7] = '{base: 10'd500,  count: 11'd7,  stride: 10'd4, ready: 4'b0101, poke: 0, exp_cyc: -1};

        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        rst_n = 1'b0; start = 1'b0; base = '0; count = '0; bus.in_ready = 1'b1;
`ifdef OPFETCH_STRIDE_EN
        stride = 10'd4;
`endif
        tb_occ = 0; pops_total = 0; done_cnt = 0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) do_run(vecs[i]);

        // Reset mid-run after the fourth word.
        begin
            int target;
            target = pops_total + 4;
            push_expect(0, 10, 4);
            done_cnt = 0;
            base = 10'd0; count = 11'd10; start = 1'b1; bus.in_ready = 1'b1;
`ifdef OPFETCH_STRIDE_EN
            stride = 10'd4;
`endif
            @(posedge clk);
            #1 start = 1'b0;
            for (int i = 0; i < 50 && pops_total < target; i++) @(posedge clk);
            #1;
            check("reset_wait", 128'(pops_total >= target), 128'd1);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrun");
            exp_addr.delete();
            exp_data.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("no_done_after_abort", 128'(done_cnt), 128'd0);
            check("idle_after_abort", 128'(busy), 128'd0);
        end
        do_run('{base: 10'd64, count: 11'd5, stride: 10'd4, ready: 4'b1111, poke: 0, exp_cyc: 8});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetcher.md
# operand_fetcher

Read sequencer that sits directly upstream of the coprocessor block memory. It walks a run of consecutive multi-cell words starting at a base address and issues `read_en`/address to the memory. It absorbs the memory's one-cycle registered read latency and delivers each word to the compute datapath over a valid/ready stream. A 2-entry skid buffer decouples consumer stalls from the memory read pipe.

## Interface
Parameters:
- `size`, 1024: memory depth in cells; must equal 2**`log_size`.
- `blocks`, 4: cells per word.
- `log_size`, 10: memory address width.
- `cell_width`, 32: bits per cell.
- `width` (localparam): `blocks*cell_width`.

Ports:
- `in_clk`, input, 1: clock, rising edge.
- `in_reset`, input, 1: asynchronous, active-low reset.
- `in_start`, input, 1: start a fetch run; sampled only in IDLE.
- `in_base_addr`, input, `log_size`: cell address of the first word.
- `in_count`, input, `log_size+1`: number of words to fetch (0..`size`).
- `in_stride`, input, `log_size`: cell increment between words. Present only with `OPFETCH_STRIDE_EN`.
- `out_mem_address`, output, `log_size`: to memory `in_address`.
- `out_mem_read_en`, output, 1: to memory `in_read_en`.
- `in_mem_data`, input, `width`: from memory `out_data`. Valid only in the cycle after a read was issued; Z otherwise.
- `out_data`, output, `width`: stream word.
- `out_valid`, output, 1: `out_data` holds a valid word.
- `in_ready`, input, 1: consumer accepts the word on a clock edge where valid&&ready.
- `out_busy`, output, 1: high in FETCH and DRAIN.
- `out_done`, output, 1: one-cycle pulse when a run completes.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - `in_start`=1 with `in_count`≠0: latch base, count and stride; go to FETCH.
  - `in_start`=1 with `in_count`=0: pulse `out_done` next cycle and stay in IDLE. No read is issued.
- FETCH: issue one read per cycle while `occupancy + inflight - pop < 2`.
  - `pop` = `out_valid && in_ready` this cycle.
  - `inflight` = 1 in the cycle after an issue.
  - After each issue, the address advances by `blocks`, or by `in_stride` when the macro is set. After the last issue (`issued == count`), go to DRAIN.
- DRAIN: when the FIFO is empty and `inflight`=0, pulse `out_done`, then return to IDLE.
- `in_start` is ignored while `out_busy`=1.
- Capture: `in_mem_data` is written into the FIFO only when `inflight`=1. The Z bus is never sampled otherwise.
- FIFO: depth 2, first-in first-out. `out_data`/`out_valid` come from the head entry. Words are delivered in address order with no drop or duplication.
- Address arithmetic is `log_size` bits and wraps modulo `size`. A word straddling cell `size-1` is a caller error and is not checked.
- `out_data` holds its value while `out_valid`=1 and `in_ready`=0.

## Timing
- Reset values: `out_mem_address`=0, `out_mem_read_en`=0, `out_data`=0, `out_valid`=0, `out_busy`=0, `out_done`=0. FSM is in IDLE; FIFO and in-flight flag are cleared.
- Reset asserted mid-run aborts immediately. Any in-flight read data is discarded, and no `out_done` is produced.
- Start latency: `in_start` sampled at edge T; the first read is issued at edge T+1 (`read_en` high during T+1..T+2).
  - The memory registers the data at T+2.
  - The fetcher captures it at T+3; `out_valid` is high from T+3.
- Throughput: 1 word/cycle while `in_ready`=1 continuously.
- A stall stops issue within one cycle, and no word is lost.
- `out_done` rises in the cycle after the last word is popped.
- Simultaneous push and pop on a full FIFO is legal; occupancy stays at 2.

## Configuration
- `OPFETCH_STRIDE_EN` defined: `in_stride` port exists, is latched at start, and sets the address increment. A stride of 0 re-reads the same word `count` times.
- `OPFETCH_STRIDE_EN` undefined: no `in_stride` port; the increment is fixed at `blocks`.

## Test plan
- Basic run: memory preloaded with cell i = i, `base`=0, `count`=10, `in_ready`=1. Expect 10 words; word k has cells {4k+3,4k+2,4k+1,4k}. Output is back-to-back after the first word, then a single `out_done`.
- Backpressure: same run with `in_ready` toggled 1,0,0,1 repeating. Expect identical word order, no duplicates, `out_data` stable during stalls, and `read_en` never issued while `occupancy+inflight`=2.
- Zero count: `in_start` with `count`=0. Expect `out_done` one cycle later, `read_en` never high, `out_valid` never high.
- Wrap-around: `base`=1016, `count`=3. Expect reads at 1016, 1020, 0, and address wraps to 0 without an error.
- Reset mid-run: `count`=10, `in_reset` low after the 4th word. Expect all outputs at reset values immediately, no `out_done`, and a fresh run afterwards that returns correct data.
- Stride (macro on): `base`=0, `stride`=8, `count`=4. Expect reads at 0, 8, 16, 24. Separately, a stride-0 run returns the same word repeated.
